// File: rtl/partial_product_accumulator.sv
// Sums NUM_GROUPS signed partial products per sample, rounds off FRAC_BITS and narrows to OUT_W.
// PushOut follows the closing beat by 2 edges, no backpressure; define PPACC_SATURATE_EN to clamp instead of wrap.
module partial_product_accumulator #(
    parameter int PP_W       = 40,
    parameter int NUM_GROUPS = 3,
    parameter int ACC_GUARD  = 2,
    parameter int FRAC_BITS  = 15,
    parameter int OUT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pp_valid,
    input  logic             pp_last,
    input  logic [PP_W-1:0]  pp_data,
    input  logic             flush,
    output logic             PushOut,
    output logic [OUT_W-1:0] DataOut,
    output logic             overflow,
    output logic             group_err
);

    localparam int ACC_W = PP_W + ACC_GUARD;
    localparam int RW    = ACC_W + 1;
    localparam int CNT_W = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
    localparam logic [CNT_W-1:0] LAST_GRP = CNT_W'(NUM_GROUPS - 1);
    localparam logic signed [RW-1:0] HALF = {{(RW-1){1'b0}}, 1'b1} << (FRAC_BITS - 1);

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] s1;
    logic signed [ACC_W-1:0] pp_ext;
    logic signed [ACC_W-1:0] sum;
    logic [CNT_W-1:0]        grp_cnt;
    logic                    s1_valid;
    logic                    at_last;
    logic                    close_ok;
    logic signed [RW-1:0]    rnd;
    logic signed [RW-1:0]    r;
    logic [OUT_W-1:0]        r_narrow;
    logic                    r_ovf;

    // First beat of a sample ignores whatever is left in acc.
    always_comb begin
        pp_ext   = ACC_W'($signed(pp_data));
        sum      = ((grp_cnt == '0) ? '0 : acc) + pp_ext;
        at_last  = (grp_cnt == LAST_GRP);
        close_ok = pp_valid && !flush && pp_last && at_last;
    end

`ifdef PPACC_SATURATE_EN
    localparam logic signed [RW-1:0] OMAX = {{(RW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [RW-1:0] OMIN = {{(RW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    always_comb begin
        rnd      = {s1[ACC_W-1], s1} + HALF;
        r        = rnd >>> FRAC_BITS;
        r_narrow = r[OUT_W-1:0];
        r_ovf    = 1'b0;
        if (r > OMAX) begin
            r_narrow = OMAX[OUT_W-1:0];
            r_ovf    = 1'b1;
        end else if (r < OMIN) begin
            r_narrow = OMIN[OUT_W-1:0];
            r_ovf    = 1'b1;
        end
    end
`else
    logic unused_r;

    always_comb begin
        rnd      = {s1[ACC_W-1], s1} + HALF;
        r        = rnd >>> FRAC_BITS;
        r_narrow = r[OUT_W-1:0];
        r_ovf    = 1'b0;
    end

    assign unused_r = ^r[RW-1:OUT_W];
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc       <= '0;
            s1        <= '0;
            grp_cnt   <= '0;
            s1_valid  <= 1'b0;
            PushOut   <= 1'b0;
            DataOut   <= '0;
            overflow  <= 1'b0;
            group_err <= 1'b0;
        end else begin
            s1_valid <= close_ok;
            if (close_ok) begin
                s1 <= sum;
            end

            // Stage 2 drains independently of flush.
            PushOut <= s1_valid;
            if (s1_valid) begin
                DataOut <= r_narrow;
                if (r_ovf) begin
                    overflow <= 1'b1;
                end
            end

            if (flush) begin
                grp_cnt <= '0;
            end else if (pp_valid) begin
                if (pp_last) begin
                    grp_cnt <= '0;
                    if (!at_last) begin
                        group_err <= 1'b1;
                    end
                end else begin
                    acc <= sum;
                    if (at_last) begin
                        group_err <= 1'b1;
                    end else begin
                        grp_cnt <= grp_cnt + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_partial_product_accumulator.sv
// Randomised and directed bench for partial_product_accumulator: a 32-bit and a 16-bit output instance share stimulus.
module tb_partial_product_accumulator;

    localparam int NG = 3;

    typedef struct {
        bit     v;
        bit     l;
        longint d;
        bit     f;
    } step_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        pp_valid;
    logic        pp_last;
    logic [39:0] pp_data;
    logic        flush;
    logic        push_a, ovf_a, gerr_a;
    logic [31:0] data_a;
    logic        push_b, ovf_b, gerr_b;
    logic [15:0] data_b;

    int checks = 0;
    int errors = 0;

    // Reference model state: beats and running sum of the open sample.
    int     m_beats;
    longint m_sum;
    bit     m_pend;
    longint m_pend_r;
    bit          e_push, e_ovf_a, e_ovf_b, e_gerr;
    logic [31:0] e_a;
    logic [15:0] e_b;

    partial_product_accumulator dut_a (
        .clk(clk), .reset(reset), .pp_valid(pp_valid), .pp_last(pp_last),
        .pp_data(pp_data), .flush(flush), .PushOut(push_a), .DataOut(data_a),
        .overflow(ovf_a), .group_err(gerr_a)
    );

    partial_product_accumulator #(.OUT_W(16)) dut_b (
        .clk(clk), .reset(reset), .pp_valid(pp_valid), .pp_last(pp_last),
        .pp_data(pp_data), .flush(flush), .PushOut(push_b), .DataOut(data_b),
        .overflow(ovf_b), .group_err(gerr_b)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic model_reset;
        m_beats = 0; m_sum = 0; m_pend = 0; m_pend_r = 0;
        e_push = 0; e_ovf_a = 0; e_ovf_b = 0; e_gerr = 0;
        e_a = '0; e_b = '0;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        pp_valid = 0; pp_last = 0; pp_data = '0; flush = 0;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Drives one cycle of inputs, advances the model across the edge, returns at the next negedge.
    task automatic beat(input bit v, input bit l, input longint d, input bit f);
        longint r;
        pp_valid = v; pp_last = l; pp_data = d[39:0]; flush = f;
        @(posedge clk);
        e_push = m_pend;
        if (m_pend) begin
            r = m_pend_r;
`ifdef PPACC_SATURATE_EN
            if (r > 64'sd2147483647) begin e_a = 32'h7FFF_FFFF; e_ovf_a = 1; end
            else if (r < -64'sd2147483648) begin e_a = 32'h8000_0000; e_ovf_a = 1; end
            else e_a = r[31:0];
            if (r > 64'sd32767) begin e_b = 16'h7FFF; e_ovf_b = 1; end
            else if (r < -64'sd32768) begin e_b = 16'h8000; e_ovf_b = 1; end
            else e_b = r[15:0];
`else
            e_a = r[31:0];
            e_b = r[15:0];
`endif
        end
        m_pend = 0;
        if (f) begin
            m_beats = 0; m_sum = 0;
        end else if (v) begin
            m_sum = m_sum + d;
            m_beats++;
            if (!l) begin
                if (m_beats >= NG) e_gerr = 1;
            end else begin
                if (m_beats >= NG) begin
                    m_pend = 1;
                    m_pend_r = (m_sum + 64'sd16384) >>> 15;
                end else begin
                    e_gerr = 1;
                end
                m_beats = 0; m_sum = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        pp_valid = 0; pp_last = 0; pp_data = '0; flush = 0;
        model_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({push_a, data_a, ovf_a, gerr_a} !== '0) begin
            errors++;
            $display("FAIL reset_a got %b expected all zero", {push_a, data_a, ovf_a, gerr_a});
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({push_b, data_b, ovf_b, gerr_b} !== '0) begin
            errors++;
            $display("FAIL reset_b got %b expected all zero", {push_b, data_b, ovf_b, gerr_b});
        end
    endtask

    task automatic test_basic;
        do_reset();
        beat(1, 0, 'h8000, 0);
        beat(1, 0, 'h8000, 0);
        beat(1, 1, 'h8000, 0);
        checks++;
        if (push_a !== 1'b0) begin errors++; $display("FAIL basic_early_push got %b expected 0", push_a); end
        beat(0, 0, 0, 0);
        checks++;
        if (push_a !== 1'b1 || data_a !== 32'd3) begin
            errors++; $display("FAIL basic_push got push=%b data=%0d expected push=1 data=3", push_a, data_a);
        end
        checks++;
        if (gerr_a !== 1'b0 || data_b !== 16'd3) begin
            errors++; $display("FAIL basic_gerr_b got gerr=%b data_b=%0d expected 0 and 3", gerr_a, data_b);
        end
        beat(0, 0, 0, 0);
        checks++;
        if (push_a !== 1'b0 || data_a !== 32'd3) begin
            errors++; $display("FAIL basic_hold got push=%b data=%0d expected push=0 data=3", push_a, data_a);
        end
    endtask

    task automatic test_rounding;
        longint vals [3] = '{64'sh4000, -64'sh4000, -64'sh4001};
        int     exps [3] = '{1, 0, -1};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            beat(1, 0, vals[i], 0);
            beat(1, 0, 0, 0);
            beat(1, 1, 0, 0);
            beat(0, 0, 0, 0);
            checks++;
            if (push_a !== 1'b1 || $signed(data_a) !== exps[i]) begin
                errors++;
                $display("FAIL round_%0d got push=%b data=%0d expected push=1 data=%0d", i, push_a, $signed(data_a), exps[i]);
            end
        end
    endtask

    task automatic test_flush;
        int pushes;
        do_reset();
        pushes = 0;
        beat(1, 0, 'h8000, 0); pushes += push_a;
        beat(1, 0, 'h8000, 0); pushes += push_a;
        beat(0, 0, 0, 1);      pushes += push_a;
        beat(1, 0, 'h8000, 0); pushes += push_a;
        beat(1, 0, 'h8000, 0); pushes += push_a;
        beat(1, 1, 'h8000, 0); pushes += push_a;
        repeat (3) begin beat(0, 0, 0, 0); pushes += push_a; end
        checks++;
        if (pushes != 1 || data_a !== 32'd3) begin
            errors++; $display("FAIL flush_resume got pushes=%0d data=%0d expected 1 and 3", pushes, data_a);
        end
        pushes = 0;
        beat(1, 0, 'h8000, 0); pushes += push_a;
        beat(1, 0, 'h8000, 0); pushes += push_a;
        beat(1, 1, 'h8000, 1); pushes += push_a;
        repeat (3) begin beat(0, 0, 0, 0); pushes += push_a; end
        checks++;
        if (pushes != 0 || gerr_a !== 1'b0) begin
            errors++; $display("FAIL flush_on_last got pushes=%0d gerr=%b expected 0 and 0", pushes, gerr_a);
        end
    endtask

    task automatic test_group_err;
        int pushes;
        do_reset();
        pushes = 0;
        beat(1, 0, 'h8000, 0); pushes += push_a;
        beat(1, 1, 'h8000, 0); pushes += push_a;
        checks++;
        if (gerr_a !== 1'b1) begin errors++; $display("FAIL gerr_short got %b expected 1", gerr_a); end
        repeat (2) begin beat(0, 0, 0, 0); pushes += push_a; end
        checks++;
        if (pushes != 0) begin errors++; $display("FAIL gerr_nopush got %0d pushes expected 0", pushes); end
        beat(1, 0, 'h8000, 0);
        beat(1, 0, 'h8000, 0);
        beat(1, 1, 'h8000, 0);
        beat(0, 0, 0, 0);
        checks++;
        if (push_a !== 1'b1 || data_a !== 32'd3 || gerr_a !== 1'b1) begin
            errors++; $display("FAIL gerr_recover got push=%b data=%0d gerr=%b expected 1 3 1", push_a, data_a, gerr_a);
        end
    endtask

    task automatic test_overflow;
        logic [15:0] exp_d;
        logic        exp_o;
`ifdef PPACC_SATURATE_EN
        exp_d = 16'h7FFF; exp_o = 1'b1;
`else
        exp_d = 16'h0000; exp_o = 1'b0;
`endif
        do_reset();
        beat(1, 0, 'h7FFFFFFF, 0);
        beat(1, 0, 'h7FFFFFFF, 0);
        beat(1, 1, 'h7FFFFFFF, 0);
        beat(0, 0, 0, 0);
        checks++;
        if (push_b !== 1'b1 || data_b !== exp_d || ovf_b !== exp_o) begin
            errors++; $display("FAIL ovf16 got push=%b data=%h ovf=%b expected 1 %h %b", push_b, data_b, ovf_b, exp_d, exp_o);
        end
        checks++;
        if (data_a !== 32'h0003_0000 || ovf_a !== 1'b0) begin
            errors++; $display("FAIL ovf32 got data=%h ovf=%b expected 00030000 0", data_a, ovf_a);
        end
    endtask

    task automatic test_reset_mid;
        int pushes;
        do_reset();
        beat(1, 0, 'h8000, 0);
        beat(1, 0, 'h8000, 0);
        beat(1, 1, 'h8000, 0);
        beat(0, 0, 0, 0);
        beat(1, 0, 'h8000, 0);
        beat(1, 0, 'h8000, 0);
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({push_a, data_a, ovf_a, gerr_a, push_b, data_b, ovf_b, gerr_b} !== '0) begin
            errors++; $display("FAIL reset_async got data_a=%0d data_b=%0d expected outputs all zero", data_a, data_b);
        end
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        pushes = 0;
        beat(1, 1, 'h8000, 0); pushes += push_a;
        repeat (3) begin beat(0, 0, 0, 0); pushes += push_a; end
        checks++;
        if (pushes != 0 || gerr_a !== 1'b1) begin
            errors++; $display("FAIL reset_then_last got pushes=%0d gerr=%b expected 0 1", pushes, gerr_a);
        end
    endtask

    task automatic test_random;
        step_t q[$];
        step_t s;
        int    kind, n;
        do_reset();
        for (int smp = 0; smp < 300; smp++) begin
            kind = $urandom_range(0, 9);
            n = (kind == 8) ? $urandom_range(1, NG - 1) : (kind == 9) ? NG + 1 : NG;
            for (int b = 0; b < n; b++) begin
                s.v = 1; s.l = (b == n - 1); s.f = 0;
                s.d = longint'({$urandom(), $urandom()}) >>> 24;
                if (kind == 7 && b == n - 2) s.f = 1;
                q.push_back(s);
                if ($urandom_range(0, 4) == 0) begin
                    s.v = 0; s.l = 0; s.d = 0; s.f = 0;
                    q.push_back(s);
                end
            end
        end
        repeat (3) begin s.v = 0; s.l = 0; s.d = 0; s.f = 0; q.push_back(s); end
        foreach (q[i]) begin
            beat(q[i].v, q[i].l, q[i].d, q[i].f);
            checks++;
            if (push_a !== e_push || push_b !== e_push) begin
                errors++; $display("FAIL rnd_push step %0d got %b/%b expected %b", i, push_a, push_b, e_push);
            end
            checks++;
            if (data_a !== e_a || data_b !== e_b) begin
                errors++; $display("FAIL rnd_data step %0d got %h/%h expected %h/%h", i, data_a, data_b, e_a, e_b);
            end
            checks++;
            if (gerr_a !== e_gerr || ovf_a !== e_ovf_a || ovf_b !== e_ovf_b) begin
                errors++; $display("FAIL rnd_flags step %0d got gerr=%b ovf=%b/%b expected %b %b/%b",
                                   i, gerr_a, ovf_a, ovf_b, e_gerr, e_ovf_a, e_ovf_b);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rounding();
        test_flush();
        test_group_err();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/partial_product_accumulator.md
Name: partial_product_accumulator

Overview:
- Downstream of the multiplier control FSM in the FIR datapath.
- Consumes one signed partial product per group, NUM_GROUPS groups per output sample, and sums them into a wide accumulator.
- On the last group, rounds the sum and drops fractional bits, then narrows to OUT_W.
- Emits the result with a one-cycle PushOut strobe.
- An abort input (driven by PushIn/PushCoef activity) discards a sample in progress.

Parameters:
- PP_W, 40, width of signed partial product input.
- NUM_GROUPS, 3, partial products per output sample.
- ACC_GUARD, 2, guard bits; accumulator width ACC_W = PP_W+ACC_GUARD.
- FRAC_BITS, 15, fractional bits removed by rounding (must be ≥1).
- OUT_W, 32, signed output width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- pp_valid  in  1  partial product valid (partialProductAccumulate_valid).
- pp_last  in  1  final group of sample (finalAccumulateRounding_en); qualified by pp_valid.
- pp_data  in  PP_W  signed partial product.
- flush  in  1  abort current sample.
- PushOut  out  1  one-cycle strobe, DataOut valid.
- DataOut  out  OUT_W  signed rounded result.
- overflow  out  1  sticky; result exceeded OUT_W range.
- group_err  out  1  sticky; pp_last count mismatch.

Behaviour:
- Reset (async, active-high) clears acc, grp_cnt, stage-1 register and valid bit. It also clears DataOut, PushOut, overflow and group_err. Effective immediately, mid-sample included.
- grp_cnt is 0..NUM_GROUPS-1 and counts accepted pp_valid beats of the current sample.
- Accumulate: on each edge with pp_valid=1 and flush=0:
  - sum = (grp_cnt==0 ? 0 : acc) + sign_extend(pp_data).
  - If pp_last=0: acc<=sum, grp_cnt<=grp_cnt+1.
  - If grp_cnt reaches NUM_GROUPS-1 with pp_last=0, set group_err. Keep accumulating with grp_cnt saturated. Next pp_last closes the sample.
- Close: pp_valid=1, pp_last=1, flush=0.
  - If grp_cnt==NUM_GROUPS-1: stage-1 register <= sum, s1_valid<=1.
  - Otherwise set group_err and emit no result.
  - Either way grp_cnt<=0.
- Round (stage 2), on the edge after s1_valid=1:
  - r = (s1 + 2^(FRAC_BITS-1)) >>> FRAC_BITS (round half up, arithmetic shift).
  - DataOut<=narrow(r), PushOut<=1, s1_valid<=0.
  - PushOut=0 on all other cycles.
- Latency: input beat with pp_last sampled at edge N gives PushOut high for the cycle following edge N+1.
- Throughput: a new sample may close every cycle (NUM_GROUPS=1 case). Back-to-back closes produce consecutive PushOut pulses.
- Narrowing without the feature: low OUT_W bits (wrap), overflow held 0.
- DataOut holds its last value while PushOut=0.
- Flush:
  - grp_cnt<=0; the partial acc is discarded; a coincident pp_valid beat is dropped.
  - A sample already in stage 1 still completes and pushes (flush does not kill it).
- Arithmetic is signed two's complement throughout. Accumulation never overflows ACC_W by construction (ACC_GUARD ≥ ceil(log2 NUM_GROUPS)).

Optional Feature:
- Macro PPACC_SATURATE_EN.
- Defined:
  - r > 2^(OUT_W-1)-1 gives DataOut = max positive.
  - r < -2^(OUT_W-1) gives DataOut = min negative.
  - Either case sets overflow (sticky until reset).
- Undefined: wrap to low OUT_W bits; overflow tied 0.

Test Plan:
- Reset, then three beats pp_data=0x8000 with pp_last on the third -> PushOut single pulse 2 cycles after the third beat, DataOut=3, group_err=0.
- Rounding boundary:
  - Beats 0x4000, 0, 0 -> DataOut=1.
  - Beats -0x4000, 0, 0 -> DataOut=0.
  - Beats -0x4001, 0, 0 -> DataOut=-1.
- Flush after two beats of 0x8000, then fresh three beats of 0x8000 -> exactly one PushOut, DataOut=3. Flush coincident with a pp_last beat -> no PushOut for that sample.
- pp_last on the second beat -> group_err=1, no PushOut. The following correct three-beat sample still gives PushOut with the correct value.
- OUT_W=16, three beats 0x7FFFFFFF:
  - With PPACC_SATURATE_EN -> DataOut=0x7FFF, overflow=1.
  - Without -> DataOut=0x0000, overflow=0.
- Assert reset between second and third beat -> outputs 0 immediately. Third beat after release counts as a first beat, not as a close.
